// File: rtl/tff_toggle_rx.sv
// Receive side of a toggle-signalling link: synchronizes i_q, turns each level flip into a
// one-cycle pulse, counts events and queues them for a valid/ready consumer.
module tff_toggle_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_q,
    input  logic              i_clr,
    input  logic              i_ready,
    output logic              o_pulse,
    output logic              o_valid,
    output logic [PEND_W-1:0] o_pending,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overflow,
    output logic              o_level
);

    localparam int PC_W = $clog2(SYNC_STAGES + 1);
    localparam logic [PC_W-1:0]   PRIME_LAST = PC_W'(SYNC_STAGES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [PC_W-1:0]        prime_cnt_q, prime_cnt_d;
    logic                   last_q, last_d;
    logic                   pulse_q, pulse_d;
    logic [PEND_W-1:0]      pending_q, pending_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   tog_s;
    logic                   pop_s;
    logic                   drop_s;

    // Synchronizer shift, priming sequence and toggle detection.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], i_q};
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        last_d      = last_q;
        pulse_d     = 1'b0;
        tog_s       = sync_q[SYNC_STAGES-1] ^ last_q;
        case (state_q)
            ST_PRIME: begin
                // The chain was cleared by reset, so take the value entering the last
                // stage on this edge: that is the line's settled level.
                if (prime_cnt_q == PRIME_LAST) begin
                    state_d = ST_RUN;
                    last_d  = sync_d[SYNC_STAGES-1];
                end else begin
                    prime_cnt_d = prime_cnt_q + PC_W'(1);
                end
            end
            ST_RUN: begin
                last_d  = sync_q[SYNC_STAGES-1];
                pulse_d = tog_s;
            end
            default: begin
                state_d = ST_PRIME;
            end
        endcase
    end

    // Pending-event queue, wrapping event count and sticky overflow.
    always_comb begin
        pop_s     = o_valid & i_ready;
        drop_s    = 1'b0;
        pending_d = pending_q;
        if (pulse_q && !pop_s) begin
            if (pending_q == PEND_MAX) begin
                drop_s = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (pop_s && !pulse_q) begin
            pending_d = pending_q - PEND_W'(1);
        end else begin
            pending_d = pending_q;
        end

        if (i_clr) begin
            count_d    = {CNT_W{1'b0}};
            overflow_d = 1'b0;
        end else begin
            count_d    = pulse_q ? count_q + CNT_W'(1) : count_q;
            overflow_d = overflow_q | drop_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PRIME;
            sync_q      <= {SYNC_STAGES{1'b0}};
            prime_cnt_q <= {PC_W{1'b0}};
            last_q      <= 1'b0;
            pulse_q     <= 1'b0;
            pending_q   <= {PEND_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            prime_cnt_q <= prime_cnt_d;
            last_q      <= last_d;
            pulse_q     <= pulse_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_pulse    = pulse_q;
    assign o_valid    = (pending_q != {PEND_W{1'b0}});
    assign o_pending  = pending_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_level    = last_q;

endmodule

// File: tb/tb_tff_toggle_rx.sv
// Self-checking bench for tff_toggle_rx: directed vector table, corner-case sequences and
// randomized toggling checked against an edge-indexed behavioural model.
module tb_tff_toggle_rx;

    localparam int S    = 2;
    localparam int CW   = 8;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst, i_q, i_clr, i_ready;
    logic          o_pulse, o_valid, o_overflow, o_level;
    logic [PW-1:0] o_pending;
    logic [CW-1:0] o_count;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Model: i_q samples per edge since reset release, plus event bookkeeping.
    bit hist[$];
    int edge_n = 0;
    bit p_m = 1'b0, ovf_m = 1'b0, lvl_m = 1'b0;
    int pend_m = 0, cnt_m = 0;

    typedef struct {
        bit rst, iq, clr, rdy;
        int n;
        bit e_pulse, e_valid;
        int e_pend, e_cnt;
        bit e_ovf, e_lvl;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    tff_toggle_rx #(.SYNC_STAGES(S), .CNT_W(CW), .PEND_W(PW)) dut (
        .clk(clk), .rst(rst), .i_q(i_q), .i_clr(i_clr), .i_ready(i_ready),
        .o_pulse(o_pulse), .o_valid(o_valid), .o_pending(o_pending),
        .o_count(o_count), .o_overflow(o_overflow), .o_level(o_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d, expected %0d", phase, name, act, exp);
        end
    endtask

    // Event at edge n (counted from release) is a difference between the i_q samples taken
    // S and S+1 edges earlier; the level register shows the sample from S edges back.
    task automatic model_edge();
        bit pop;
        bit newp;
        if (rst) begin
            hist.delete();
            edge_n = 0;
            p_m = 1'b0; ovf_m = 1'b0; lvl_m = 1'b0;
            pend_m = 0; cnt_m = 0;
        end else begin
            pop = (pend_m != 0) && i_ready;
            edge_n++;
            hist.push_back(i_q);
            if (p_m && !pop) begin
                if (pend_m == PMAX) ovf_m = 1'b1;
                else pend_m++;
            end else if (pop && !p_m) begin
                pend_m--;
            end
            if (i_clr) begin
                cnt_m = 0;
                ovf_m = 1'b0;
            end else if (p_m) begin
                cnt_m = (cnt_m + 1) % (1 << CW);
            end
            newp = (edge_n >= S + 2) && (hist[hist.size()-1-S] != hist[hist.size()-2-S]);
            if (edge_n < S) lvl_m = 1'b0;
            else if (edge_n == S) lvl_m = hist[0];
            else lvl_m = hist[hist.size()-1-S];
            p_m = newp;
            while (hist.size() > S + 2) void'(hist.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pulse", o_pulse, p_m);
        check("valid", o_valid, pend_m != 0);
        check("pending", o_pending, pend_m);
        check("count", o_count, cnt_m);
        check("overflow", o_overflow, ovf_m);
        check("level", o_level, lvl_m);
    endtask

    task automatic do_reset(input bit level);
        rst = 1'b1; i_q = level; i_clr = 1'b0; i_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        int hold;
        rst = 1'b1; i_q = 1'b0; i_clr = 1'b0; i_ready = 1'b0;

        //             rst   iq    clr   rdy   n   pulse valid pend cnt ovf  lvl
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 2,  1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 6,  1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 2,  1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0, 0, 0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1, 1, 1, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b1, 2, 2, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 4,  1'b0, 1'b1, 3, 3, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, 1,  1'b0, 1'b1, 2, 3, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, 1,  1'b0, 1'b1, 1, 3, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, 1,  1'b0, 1'b0, 0, 3, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b1, 1,  1'b0, 1'b0, 0, 3, 1'b0, 1'b1});

        phase = "table";
        for (int v = 0; v < vecs.size(); v++) begin
            rst = vecs[v].rst; i_q = vecs[v].iq; i_clr = vecs[v].clr; i_ready = vecs[v].rdy;
            for (int c = 0; c < vecs[v].n; c++) step();
            check($sformatf("row%0d_pulse", v), o_pulse, vecs[v].e_pulse);
            check($sformatf("row%0d_valid", v), o_valid, vecs[v].e_valid);
            check($sformatf("row%0d_pending", v), o_pending, vecs[v].e_pend);
            check($sformatf("row%0d_count", v), o_count, vecs[v].e_cnt);
            check($sformatf("row%0d_overflow", v), o_overflow, vecs[v].e_ovf);
            check($sformatf("row%0d_level", v), o_level, vecs[v].e_lvl);
        end

        // Fill the queue past its limit, then clear the sticky flag and counter.
        phase = "overflow";
        do_reset(1'b0);
        for (int c = 0; c < 4; c++) step();
        for (int t = 0; t < 16; t++) begin
            i_q = ~i_q;
            step(); step();
        end
        for (int c = 0; c < 4; c++) step();
        check("full_pending", o_pending, 15);
        check("full_overflow", o_overflow, 1);
        check("full_count", o_count, 16);
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        check("clr_overflow", o_overflow, 0);
        check("clr_count", o_count, 0);
        check("clr_pending", o_pending, 15);

        // Pop on the same cycle as a new pulse at a full queue.
        phase = "full_pop";
        i_q = ~i_q;
        step(); step(); step();
        check("pulse_fires", o_pulse, 1);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("pending_held", o_pending, 15);
        check("no_overflow", o_overflow, 0);
        step();

        // Counter wrap, then reset in the middle of traffic.
        phase = "wrap";
        do_reset(1'b0);
        for (int c = 0; c < 4; c++) step();
        for (int t = 0; t < 257; t++) begin
            i_q = ~i_q;
            i_ready = 1'($urandom_range(0, 1));
            step(); step();
        end
        i_ready = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("wrap_count", o_count, 1);
        i_q = ~i_q;
        step(); step();
        rst = 1'b1;
        step();
        check("rst_pulse", o_pulse, 0);
        check("rst_valid", o_valid, 0);
        check("rst_pending", o_pending, 0);
        check("rst_count", o_count, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_level", o_level, 0);
        rst = 1'b0;
        for (int c = 0; c <= S; c++) begin
            if (c % 2 == 0) i_q = ~i_q;
            step();
            check($sformatf("prime_quiet%0d", c), o_pulse, 0);
        end

        // Random traffic with occasional clears and resets.
        phase = "random";
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                i_q = ~i_q;
                hold = $urandom_range(2, 6);
            end
            hold--;
            i_ready = ($urandom_range(0, 3) == 0);
            i_clr   = ($urandom_range(0, 49) == 0);
            rst     = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0; i_clr = 1'b0; i_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
